io_access_sequencer: RTL and testbench

- Multi-cycle memory-mapped I/O controller in the pipeline MEM stage; I/O space is dataAddr[31:28]=4'hF, device selected by dataAddr[7:0].
- Holds the pipeline with a stall while an I/O load or store runs through a programmable wait-state sequence.
- Owns the board-facing registers: HEX, LEDR, LEDG, synchronized and debounced SW, and a KEY edge-capture register with ready and overrun flags.
- Non-I/O stores go straight to data memory through dataWrtEn with no stall.

---
 rtl/io_access_sequencer_pkg.sv | 11 +
 rtl/io_access_sequencer_sync.sv | 34 +++
 rtl/io_access_sequencer.sv | 110 +++++++++++
 tb/tb_io_access_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_access_sequencer_pkg.sv
// io_access_sequencer_pkg: I/O address map constants and sequencer state encoding
package io_access_sequencer_pkg;
    localparam logic [3:0] IO_SPACE  = 4'hF;
    localparam logic [7:0] OFF_HEX   = 8'h00;
    localparam logic [7:0] OFF_LEDR  = 8'h04;
    localparam logic [7:0] OFF_LEDG  = 8'h08;
    localparam logic [7:0] OFF_KEY   = 8'h10;
    localparam logic [7:0] OFF_SW    = 8'h14;
    localparam logic [7:0] OFF_KCTRL = 8'h18;
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
endpackage

// File: rtl/io_access_sequencer_sync.sv
// io_sync_debounce: 2-flop synchronizer feeding a candidate register that is accepted after a stable run
module io_sync_debounce #(
    parameter int           W               = 10,
    parameter int           DEBOUNCE_CYCLES = 16,
    parameter logic [W-1:0] RST_VAL         = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    logic [W-1:0]  r_s1, r_s2, r_cand, r_q;
    logic [CW-1:0] r_cnt;
    logic          w_stable;
    assign w_stable = r_s2 == r_cand;
    assign o_q      = r_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1   <= RST_VAL;
            r_s2   <= RST_VAL;
            r_cand <= RST_VAL;
            r_q    <= RST_VAL;
            r_cnt  <= '0;
        end else begin
            r_s1   <= i_d;
            r_s2   <= r_s1;
            r_cand <= r_s2;
            r_cnt  <= !w_stable ? '0 : (r_cnt == CNT_MAX ? r_cnt : r_cnt + 1'b1);
            if (w_stable && r_cnt == CNT_MAX) r_q <= r_cand;
        end
    end
endmodule

// File: rtl/io_access_sequencer.sv
// io_access_sequencer: MEM-stage wait-state sequencer for memory-mapped board I/O
module io_access_sequencer
    import io_access_sequencer_pkg::*;
#(
    parameter int DBITS           = 32,
    parameter int WAIT_CYCLES     = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] dataAddr,
    input  logic             isLoad,
    input  logic             isStore,
    input  logic [DBITS-1:0] wrtData,
    output logic             dataWrtEn,
    output logic             stall,
    output logic [DBITS-1:0] ioRdData,
    output logic             ioRdValid,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [9:0]       LEDR,
    output logic [7:0]       LEDG,
    output logic [15:0]      HEX
);
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
    state_t           r_state, w_next;
    logic [3:0]       r_cnt, r_key_prev, w_key_sync, w_key_state;
    logic [7:0]       r_off, r_ledg;
    logic             r_is_load, r_ready, r_overrun;
    logic [15:0]      r_wdata, r_hex;
    logic [9:0]       r_ledr, w_sw;
    logic [DBITS-1:0] r_rd_hold, w_rd;
    logic             w_io_space, w_io_req, w_done, w_rd_done, w_wr_done;
    logic             w_key_edge, w_key_clr, w_ovr_clr, w_unused;
    io_sync_debounce #(.W(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(10'h000)) u_sw (
        .clk(clk), .reset(reset), .i_d(SW), .o_q(w_sw)
    );
    // KEY idles high (released), so its synchronizer resets to all ones to avoid a false edge
    io_sync_debounce #(.W(4), .DEBOUNCE_CYCLES(1), .RST_VAL(4'hF)) u_key (
        .clk(clk), .reset(reset), .i_d(KEY), .o_q(w_key_sync)
    );
    assign w_unused    = &{1'b0, dataAddr[DBITS-5:8], wrtData[DBITS-1:16]};
    assign w_io_space  = dataAddr[DBITS-1 -: 4] == IO_SPACE;
    assign w_io_req    = (isLoad | isStore) & w_io_space;
    assign dataWrtEn   = isStore & ~isLoad & ~w_io_space;
    assign stall       = ((r_state == S_IDLE) & w_io_req) | (r_state == S_ACCESS);
    assign w_done      = r_state == S_DONE;
    assign w_rd_done   = w_done & r_is_load;
    assign w_wr_done   = w_done & ~r_is_load;
    assign ioRdValid   = w_rd_done;
    assign ioRdData    = w_rd_done ? w_rd : r_rd_hold;
    assign w_key_state = ~w_key_sync;
    assign w_key_edge  = |(w_key_state & ~r_key_prev);
    assign w_key_clr   = w_rd_done & (r_off == OFF_KEY);
    assign w_ovr_clr   = w_wr_done & (r_off == OFF_KCTRL) & ~r_wdata[1];
    assign LEDR        = r_ledr;
    assign LEDG        = r_ledg;
    assign HEX         = r_hex;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = !w_io_req ? S_IDLE : (WAIT_CYCLES == 0 ? S_DONE : S_ACCESS);
            S_ACCESS: w_next = !w_io_req ? S_IDLE : (r_cnt == 4'd0 ? S_DONE : S_ACCESS);
            default:  w_next = S_IDLE;
        endcase
    end
    always_comb begin
        w_rd = '0;
        case (r_off)
            OFF_KEY:   w_rd[3:0] = w_key_state;
            OFF_SW:    w_rd[9:0] = w_sw;
            OFF_KCTRL: w_rd[1:0] = {r_overrun, r_ready};
            default:   w_rd = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_off      <= '0;
            r_is_load  <= 1'b0;
            r_wdata    <= '0;
            r_rd_hold  <= '0;
            r_ledr     <= '0;
            r_ledg     <= '0;
            r_hex      <= '0;
            r_key_prev <= '0;
            r_ready    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_io_req) begin
                r_cnt     <= CNT_LOAD;
                r_off     <= dataAddr[7:0];
                r_is_load <= isLoad;
                r_wdata   <= wrtData[15:0];
            end else if (r_state == S_ACCESS) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_rd_done) r_rd_hold <= w_rd;
            if (w_wr_done && r_off == OFF_HEX) r_hex <= r_wdata;
            if (w_wr_done && r_off == OFF_LEDR) r_ledr <= r_wdata[9:0];
            if (w_wr_done && r_off == OFF_LEDG) r_ledg <= r_wdata[7:0];
            r_key_prev <= w_key_state;
            // a fresh edge beats a same-cycle KEY-read clear and then does not count as an overrun
            r_ready   <= w_key_edge | (r_ready & ~w_key_clr);
            r_overrun <= (w_key_edge & r_ready & ~w_key_clr) | (r_overrun & ~w_ovr_clr);
        end
    end
endmodule

// File: tb/tb_io_access_sequencer.sv
// tb_io_access_sequencer: table, directed and randomized checks against a behavioural I/O model
module tb_io_access_sequencer;
    localparam int WAIT = 1;
    typedef struct {
        logic [31:0] a;
        logic        ld, st;
        logic [31:0] wd, rd;
        logic        we;
        logic [9:0]  ledr;
        logic [7:0]  ledg;
        logic [15:0] hex;
    } vec_t;
    logic        clk = 0, reset = 1;
    logic [31:0] dataAddr = 0, wrtData = 0, ioRdData;
    logic        isLoad = 0, isStore = 0, dataWrtEn, stall, ioRdValid;
    logic [3:0]  KEY = 4'hF;
    logic [9:0]  SW = 0, LEDR;
    logic [7:0]  LEDG;
    logic [15:0] HEX;
    logic [31:0] addr3 = 0, wd3 = 0, ioRdData3;
    logic        ld3 = 0, st3 = 0, dataWrtEn3, stall3, ioRdValid3;
    logic [3:0]  key3 = 4'hF;
    logic [9:0]  sw3 = 0, ledr3;
    logic [7:0]  ledg3;
    logic [15:0] hex3;
    int          n_vec = 0, n_err = 0;
    logic [9:0]  m_ledr = 0, m_sw = 0;
    logic [7:0]  m_ledg = 0;
    logic [15:0] m_hex = 0;
    logic [3:0]  m_key = 4'hF;
    logic        m_ready = 0, m_ovr = 0;
    always #5 clk = ~clk;
    io_access_sequencer #(.DBITS(32), .WAIT_CYCLES(WAIT), .DEBOUNCE_CYCLES(16)) u_dut (
        .clk(clk), .reset(reset), .dataAddr(dataAddr), .isLoad(isLoad), .isStore(isStore),
        .wrtData(wrtData), .dataWrtEn(dataWrtEn), .stall(stall), .ioRdData(ioRdData),
        .ioRdValid(ioRdValid), .KEY(KEY), .SW(SW), .LEDR(LEDR), .LEDG(LEDG), .HEX(HEX)
    );
    io_access_sequencer #(.DBITS(32), .WAIT_CYCLES(3), .DEBOUNCE_CYCLES(4)) u_dut3 (
        .clk(clk), .reset(reset), .dataAddr(addr3), .isLoad(ld3), .isStore(st3),
        .wrtData(wd3), .dataWrtEn(dataWrtEn3), .stall(stall3), .ioRdData(ioRdData3),
        .ioRdValid(ioRdValid3), .KEY(key3), .SW(sw3), .LEDR(ledr3), .LEDG(ledg3), .HEX(hex3)
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask
    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        case (a[7:0])
            8'h10:   return {28'b0, ~m_key};
            8'h14:   return {22'b0, m_sw};
            8'h18:   return {30'b0, m_ovr, m_ready};
            default: return 32'h0;
        endcase
    endfunction
    task automatic mdl_after(input logic [31:0] a, input logic ld, input logic st, input logic [31:0] wd);
        if (ld) begin
            if (a[7:0] == 8'h10) m_ready = 0;
        end else if (st) begin
            case (a[7:0])
                8'h00:   m_hex = wd[15:0];
                8'h04:   m_ledr = wd[9:0];
                8'h08:   m_ledg = wd[7:0];
                8'h18:   if (!wd[1]) m_ovr = 0;
                default: ;
            endcase
        end
    endtask
    task automatic io_access(input logic [31:0] a, input logic ld, input logic st,
                             input logic [31:0] wd, input logic [31:0] exp_rd, input string nm);
        int   n = 0;
        logic saw_we = 0;
        dataAddr = a; isLoad = ld; isStore = st; wrtData = wd;
        #1;
        while (stall && n < 40) begin
            saw_we |= dataWrtEn;
            n++;
            @(posedge clk);
            #2;
        end
        chk({nm, " stall cycles"}, n, 1 + WAIT);
        chk({nm, " dataWrtEn"}, {31'b0, saw_we | dataWrtEn}, 0);
        chk({nm, " valid"}, {31'b0, ioRdValid}, {31'b0, ld});
        if (ld) chk({nm, " rdata"}, ioRdData, exp_rd);
        @(posedge clk);
        #1;
        isLoad = 0; isStore = 0;
        #1;
        if (ld) begin
            chk({nm, " valid drop"}, {31'b0, ioRdValid}, 0);
            chk({nm, " rdata hold"}, ioRdData, exp_rd);
        end
    endtask
    task automatic do_io(input logic [31:0] a, input logic ld, input logic st, input logic [31:0] wd, input string nm);
        io_access(a, ld, st, wd, mdl_rd(a), nm);
        mdl_after(a, ld, st, wd);
    endtask
    task automatic set_key(input logic [3:0] k);
        if ((m_key & ~k) != 4'h0) begin
            m_ovr = m_ovr | m_ready;
            m_ready = 1;
        end
        KEY = k; m_key = k;
        idle_n(8);
    endtask
    task automatic set_sw(input logic [9:0] v);
        SW = v; m_sw = v;
        idle_n(25);
    endtask
    task automatic chk_regs(input string nm);
        chk({nm, " LEDR"}, {22'b0, LEDR}, {22'b0, m_ledr});
        chk({nm, " LEDG"}, {24'b0, LEDG}, {24'b0, m_ledg});
        chk({nm, " HEX"}, {16'b0, HEX}, {16'b0, m_hex});
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        vec_t        tbl[15];
        vec_t        v;
        logic [7:0]  offs[8];
        logic [31:0] a, wd;
        logic [9:0]  sw_keep;
        int          n, bad;
        offs = '{8'h10, 8'h14, 8'h18, 8'h0C, 8'h40, 8'hFF, 8'h00, 8'h04};
        tbl[0]  = '{32'hF0000004, 1'b0, 1'b1, 32'h000002A5, 32'h0, 1'b0, 10'h2A5, 8'h00, 16'h0000};
        tbl[1]  = '{32'h00000100, 1'b0, 1'b1, 32'h0000DEAD, 32'h0, 1'b1, 10'h2A5, 8'h00, 16'h0000};
        tbl[2]  = '{32'hF0000008, 1'b0, 1'b1, 32'h000001C3, 32'h0, 1'b0, 10'h2A5, 8'hC3, 16'h0000};
        tbl[3]  = '{32'hF0000000, 1'b0, 1'b1, 32'hABCD1234, 32'h0, 1'b0, 10'h2A5, 8'hC3, 16'h1234};
        tbl[4]  = '{32'hF00000FC, 1'b0, 1'b1, 32'h0000FFFF, 32'h0, 1'b0, 10'h2A5, 8'hC3, 16'h1234};
        tbl[5]  = '{32'hF0000020, 1'b1, 1'b0, 32'h0,        32'h0, 1'b0, 10'h2A5, 8'hC3, 16'h1234};
        tbl[6]  = '{32'hF0000004, 1'b1, 1'b1, 32'h000003FF, 32'h0, 1'b0, 10'h2A5, 8'hC3, 16'h1234};
        tbl[7]  = '{32'h00000200, 1'b1, 1'b1, 32'h00000055, 32'h0, 1'b0, 10'h2A5, 8'hC3, 16'h1234};
        tbl[8]  = '{32'h00000300, 1'b1, 1'b0, 32'h0,        32'h0, 1'b0, 10'h2A5, 8'hC3, 16'h1234};
        tbl[9]  = '{32'hF0000018, 1'b1, 1'b0, 32'h0,        32'h0, 1'b0, 10'h2A5, 8'hC3, 16'h1234};
        tbl[10] = '{32'hF0000010, 1'b1, 1'b0, 32'h0,        32'h0, 1'b0, 10'h2A5, 8'hC3, 16'h1234};
        tbl[11] = '{32'hF0000014, 1'b1, 1'b0, 32'h0,        32'h0, 1'b0, 10'h2A5, 8'hC3, 16'h1234};
        tbl[12] = '{32'hE0000004, 1'b0, 1'b1, 32'h00000111, 32'h0, 1'b1, 10'h2A5, 8'hC3, 16'h1234};
        tbl[13] = '{32'hF000000C, 1'b0, 1'b1, 32'h00000077, 32'h0, 1'b0, 10'h2A5, 8'hC3, 16'h1234};
        tbl[14] = '{32'hF0000004, 1'b0, 1'b1, 32'hFFFFFC01, 32'h0, 1'b0, 10'h001, 8'hC3, 16'h1234};
        idle_n(3);
        chk("reset stall", {31'b0, stall}, 0);
        chk("reset valid", {31'b0, ioRdValid}, 0);
        chk("reset rdata", ioRdData, 0);
        chk_regs("reset");
        reset = 0;
        idle_n(3);
        for (int i = 0; i < 15; i++) begin
            v = tbl[i];
            if (v.a[31:28] == 4'hF) begin
                io_access(v.a, v.ld, v.st, v.wd, v.rd, $sformatf("tbl%0d", i));
                mdl_after(v.a, v.ld, v.st, v.wd);
            end else begin
                dataAddr = v.a; isLoad = v.ld; isStore = v.st; wrtData = v.wd;
                #1;
                chk($sformatf("tbl%0d dataWrtEn", i), {31'b0, dataWrtEn}, {31'b0, v.we});
                chk($sformatf("tbl%0d stall", i), {31'b0, stall}, 0);
                cyc();
                isLoad = 0; isStore = 0;
                #1;
            end
            chk($sformatf("tbl%0d LEDR", i), {22'b0, LEDR}, {22'b0, v.ledr});
            chk($sformatf("tbl%0d LEDG", i), {24'b0, LEDG}, {24'b0, v.ledg});
            chk($sformatf("tbl%0d HEX", i), {16'b0, HEX}, {16'b0, v.hex});
        end
        set_sw(10'h0AA);
        do_io(32'hF0000014, 1, 0, 0, "sw settle");
        SW = 10'h155; idle_n(5);
        SW = 10'h000; idle_n(3);
        SW = 10'h155; idle_n(2);
        io_access(32'hF0000014, 1, 0, 0, 32'h0AA, "sw early");
        idle_n(25);
        m_sw = 10'h155;
        io_access(32'hF0000014, 1, 0, 0, 32'h155, "sw stable");
        set_key(4'b1011);
        io_access(32'hF0000018, 1, 0, 0, 32'h1, "kctrl ready");
        set_key(4'b1010);
        io_access(32'hF0000018, 1, 0, 0, 32'h3, "kctrl overrun");
        io_access(32'hF0000010, 1, 0, 0, 32'h5, "key read");
        m_ready = 0;
        io_access(32'hF0000018, 1, 0, 0, 32'h2, "kctrl after read");
        io_access(32'hF0000018, 0, 1, 32'h0, 32'h0, "kctrl clr");
        m_ovr = 0;
        io_access(32'hF0000018, 1, 0, 0, 32'h0, "kctrl cleared");
        set_key(4'hF);
        cyc();
        KEY = 4'b1101; m_key = 4'b1101;
        cyc(); cyc();
        io_access(32'hF0000010, 1, 0, 0, 32'h2, "collide key");
        m_ready = 1;
        io_access(32'hF0000018, 1, 0, 0, 32'h1, "collide kctrl");
        set_key(4'hF);
        key3 = 4'b1110; idle_n(8);
        addr3 = 32'hF0000010; ld3 = 1;
        cyc(); cyc();
        ld3 = 0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            bad |= {31'b0, ioRdValid3};
            cyc();
        end
        chk("abort valid", bad, 0);
        chk("abort stall", {31'b0, stall3}, 0);
        addr3 = 32'hF0000018; ld3 = 1;
        #1;
        n = 0;
        while (stall3 && n < 40) begin
            n++;
            @(posedge clk);
            #2;
        end
        chk("w3 stall cycles", n, 4);
        chk("w3 valid", {31'b0, ioRdValid3}, 1);
        chk("w3 kctrl", ioRdData3, 32'h1);
        cyc();
        ld3 = 0;
        for (int i = 0; i < 60; i++) begin
            wd = $urandom;
            case ($urandom_range(0, 7))
                0: do_io({4'hF, 20'($urandom), 8'h00}, 0, 1, wd, "rnd hex");
                1: do_io({4'hF, 20'($urandom), 8'h04}, 0, 1, wd, "rnd ledr");
                2: do_io({4'hF, 20'($urandom), 8'h08}, 0, 1, wd, "rnd ledg");
                3: do_io({4'hF, 20'($urandom), 8'h18}, 0, 1, wd, "rnd kctrl st");
                4: begin
                    a = {4'hF, 20'($urandom), offs[$urandom_range(0, 7)]};
                    do_io(a, 1, 0, wd, $sformatf("rnd ld %0h", a[7:0]));
                end
                5: set_key(4'($urandom));
                6: set_sw(10'($urandom));
                default: begin
                    dataAddr = {4'($urandom_range(0, 14)), 28'($urandom)};
                    isStore = 1; isLoad = 0; wrtData = wd;
                    #1;
                    chk("rnd mem we", {31'b0, dataWrtEn}, 1);
                    chk("rnd mem stall", {31'b0, stall}, 0);
                    cyc();
                    isStore = 0;
                    #1;
                end
            endcase
            chk_regs($sformatf("rnd%0d", i));
        end
        set_key(4'hF);
        set_sw(10'h3C3);
        do_io(32'hF0000004, 0, 1, 32'h3FF, "pre-reset ledr");
        cyc();
        dataAddr = 32'hF0000000; isStore = 1; isLoad = 0; wrtData = 32'h1234;
        #1;
        chk("rst idle stall", {31'b0, stall}, 1);
        cyc();
        chk("rst access stall", {31'b0, stall}, 1);
        reset = 1; isStore = 0;
        cyc();
        reset = 0;
        #1;
        chk("rst stall", {31'b0, stall}, 0);
        chk("rst valid", {31'b0, ioRdValid}, 0);
        chk("rst rdata", ioRdData, 0);
        m_ledr = 0; m_ledg = 0; m_hex = 0; m_ready = 0; m_ovr = 0;
        chk_regs("rst");
        idle_n(4);
        chk_regs("post rst");
        do_io(32'hF0000018, 1, 0, 0, "post rst kctrl");
        sw_keep = m_sw; m_sw = 0;
        do_io(32'hF0000014, 1, 0, 0, "post rst sw");
        idle_n(25);
        m_sw = sw_keep;
        do_io(32'hF0000014, 1, 0, 0, "post rst sw settle");
        chk_regs("final");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
